// File: rtl/pll_reset_sequencer_if.sv
// Sequencer <-> system boundary: PLL lock input, software restart, PLL/stage resets and status.
// Latency: none (wires only).
// Backpressure: none; all signals are level or single-cycle pulses.
//
// Ports (master = sequencer side):
//   pll_locked       PLL lock indicator, asynchronous to the sequencer clock
//   sw_reset_req     one-cycle synchronous request to restart the whole sequence
//   pll_rst          active-high reset to the PLL
//   stage_rst        active-high downstream resets, bit 0 released first
//   ready            all stages released and lock held
//   lock_timeout     sticky lock-timeout flag
//   lock_loss_count  saturating count of lock drops after release started
interface pll_reset_sequencer_if #(
   parameter int NUM_STAGES = 3
);
   logic                  pll_locked;
   logic                  sw_reset_req;
   logic                  pll_rst;
   logic [NUM_STAGES-1:0] stage_rst;
   logic                  ready;
   logic                  lock_timeout;
   logic [7:0]            lock_loss_count;

   modport master (
      input  pll_locked,
      input  sw_reset_req,
      output pll_rst,
      output stage_rst,
      output ready,
      output lock_timeout,
      output lock_loss_count
   );

   modport slave (
      output pll_locked,
      output sw_reset_req,
      input  pll_rst,
      input  stage_rst,
      input  ready,
      input  lock_timeout,
      input  lock_loss_count
   );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: resets the PLL, waits for stable lock, then releases downstream resets one stage at a time.
// Latency: all outputs registered; lock changes are seen SYNC_STAGES cycles late through the synchronizer.
// Backpressure: none; lock loss or sw_reset_req restarts the sequence from PLL_RST on the next cycle.
//
// Ports:
//   clk  PLL output clock the block runs on
//   rst  asynchronous active-high reset
//   bus  pll_reset_sequencer_if.master (lock input, sw request, PLL/stage resets, status)
module pll_reset_sequencer #(
   parameter int SYNC_STAGES         = 2,
   parameter int PLL_RST_CYCLES      = 8,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int NUM_STAGES          = 3,
   parameter int STAGE_GAP_CYCLES    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   pll_reset_sequencer_if.master    bus
);

   localparam int GAP_MAX = NUM_STAGES * STAGE_GAP_CYCLES;
   localparam int RST_CW  = $clog2(PLL_RST_CYCLES) + 1;
   localparam int STB_CW  = $clog2(LOCK_STABLE_CYCLES) + 1;
   localparam int TO_CW   = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
   localparam int GAP_CW  = $clog2(GAP_MAX) + 1;

   localparam logic [RST_CW-1:0] RST_LAST = RST_CW'(PLL_RST_CYCLES - 1);
   localparam logic [STB_CW-1:0] STB_LIM  = STB_CW'(LOCK_STABLE_CYCLES);
   localparam logic [TO_CW-1:0]  TO_LIM   = TO_CW'(LOCK_TIMEOUT_CYCLES);
   localparam logic [GAP_CW-1:0] GAP_LIM  = GAP_CW'(GAP_MAX);

   typedef enum logic [1:0] {
      S_PLL_RST,
      S_WAIT_LOCK,
      S_RELEASE,
      S_RUN
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [SYNC_STAGES-1:0]  r_sync;
   logic                    w_lock_s;
   logic [RST_CW-1:0]       r_rst_cnt,    w_rst_cnt_nxt;
   logic [STB_CW-1:0]       r_stable_cnt, w_stable_nxt;
   logic [TO_CW-1:0]        r_to_cnt,     w_to_nxt;
   logic [GAP_CW-1:0]       r_gap_cnt,    w_gap_nxt;
   logic [NUM_STAGES-1:0]   r_stage_rst,  w_stage_nxt;
   logic                    r_pll_rst;
   logic                    r_ready;
   logic                    r_lock_timeout, w_timeout_nxt;
   logic [7:0]              r_loss_cnt,   w_loss_nxt;

   assign w_lock_s = r_sync[SYNC_STAGES-1];

   // Synchronizer is held clear while the PLL is in reset, so a stale lock
   // from before the reset pulse can never count toward stability.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
      end else if (r_state == S_PLL_RST) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], bus.pll_locked};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_PLL_RST;
         r_rst_cnt      <= '0;
         r_stable_cnt   <= '0;
         r_to_cnt       <= '0;
         r_gap_cnt      <= '0;
         r_stage_rst    <= '1;
         r_pll_rst      <= 1'b1;
         r_ready        <= 1'b0;
         r_lock_timeout <= 1'b0;
         r_loss_cnt     <= '0;
      end else begin
         r_state        <= w_state_nxt;
         r_rst_cnt      <= w_rst_cnt_nxt;
         r_stable_cnt   <= w_stable_nxt;
         r_to_cnt       <= w_to_nxt;
         r_gap_cnt      <= w_gap_nxt;
         r_stage_rst    <= w_stage_nxt;
         r_pll_rst      <= (w_state_nxt == S_PLL_RST);
         r_ready        <= (w_state_nxt == S_RUN);
         r_lock_timeout <= w_timeout_nxt;
         r_loss_cnt     <= w_loss_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_rst_cnt_nxt = '0;
      w_stable_nxt  = '0;
      w_to_nxt      = '0;
      w_gap_nxt     = '0;
      w_stage_nxt   = r_stage_rst;
      w_timeout_nxt = r_lock_timeout;
      w_loss_nxt    = r_loss_cnt;

      case (r_state)
         S_PLL_RST: begin
            w_stage_nxt = '1;
            if (r_rst_cnt == RST_LAST) begin
               w_state_nxt = S_WAIT_LOCK;
            end else begin
               w_rst_cnt_nxt = r_rst_cnt + 1'b1;
            end
         end

         S_WAIT_LOCK: begin
            w_stage_nxt  = '1;
            w_stable_nxt = w_lock_s ? r_stable_cnt + 1'b1 : '0;
            w_to_nxt     = r_to_cnt + 1'b1;
            // Stability is tested first so it wins a same-cycle tie with the timeout.
            if (w_stable_nxt == STB_LIM) begin
               w_state_nxt = S_RELEASE;
            end else if (w_to_nxt == TO_LIM) begin
               w_timeout_nxt = 1'b1;
               w_state_nxt   = S_PLL_RST;
            end
         end

         S_RELEASE: begin
            if (r_gap_cnt == GAP_LIM) begin
               w_state_nxt = S_RUN;
            end else begin
               w_gap_nxt = r_gap_cnt + 1'b1;
            end
            // Bit k drops once (k+1) gaps have elapsed; released bits stay low.
            for (int k = 0; k < NUM_STAGES; k++) begin
               if (w_gap_nxt >= GAP_CW'((k + 1) * STAGE_GAP_CYCLES)) begin
                  w_stage_nxt[k] = 1'b0;
               end
            end
         end

         S_RUN: begin
            w_stage_nxt = r_stage_rst;
         end

         default: begin
            w_state_nxt = S_PLL_RST;
         end
      endcase

      // Lock drops after release started are real losses; in WAIT_LOCK they only clear the stable count.
      if ((r_state == S_RELEASE || r_state == S_RUN) && !w_lock_s) begin
         w_state_nxt = S_PLL_RST;
         w_loss_nxt  = (r_loss_cnt == 8'hFF) ? r_loss_cnt : r_loss_cnt + 8'd1;
      end

      // Software restart also restarts the PLL reset pulse when already in PLL_RST.
      if (bus.sw_reset_req) begin
         w_state_nxt   = S_PLL_RST;
         w_rst_cnt_nxt = '0;
      end

      if (w_state_nxt == S_PLL_RST) begin
         w_stage_nxt = '1;
      end
      if (w_state_nxt != S_WAIT_LOCK) begin
         w_stable_nxt = '0;
         w_to_nxt     = '0;
      end
      if (w_state_nxt != S_RELEASE) begin
         w_gap_nxt = '0;
      end
      if (w_state_nxt == S_RUN) begin
         w_timeout_nxt = 1'b0;
      end
   end

   assign bus.pll_rst         = r_pll_rst;
   assign bus.stage_rst       = r_stage_rst;
   assign bus.ready           = r_ready;
   assign bus.lock_timeout    = r_lock_timeout;
   assign bus.lock_loss_count = r_loss_cnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: cycle table for bring-up plus
// hand-written sequences for glitch, timeout, lock loss, sw restart and async reset.
module tb_pll_reset_sequencer;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   pll_reset_sequencer_if #(.NUM_STAGES(3)) u_if ();

   pll_reset_sequencer #(
      .SYNC_STAGES        (2),
      .PLL_RST_CYCLES     (4),
      .LOCK_STABLE_CYCLES (8),
      .LOCK_TIMEOUT_CYCLES(64),
      .NUM_STAGES         (3),
      .STAGE_GAP_CYCLES   (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       locked;
      logic       sw;
      logic       exp_pll_rst;
      logic [2:0] exp_stage;
      logic       exp_ready;
      logic       exp_to;
      logic [7:0] exp_cnt;
   } vec_t;

   vec_t vecs [24];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (u_if.ready !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      chk(name, {31'd0, u_if.ready}, 32'd1);
   endtask

   // Drop lock while in RUN; lock_s falls two edges later, reset reasserts one edge after that.
   task automatic lose_lock(input logic [7:0] exp_cnt);
      u_if.pll_locked = 1'b0;
      tick();
      tick();
      chk("loss_ready_before", {31'd0, u_if.ready}, 32'd1);
      tick();
      chk("loss_ready", {31'd0, u_if.ready}, 32'd0);
      chk("loss_stage", {29'd0, u_if.stage_rst}, 32'd7);
      chk("loss_count", {24'd0, u_if.lock_loss_count}, {24'd0, exp_cnt});
      u_if.pll_locked = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int n;
      int e;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      u_if.pll_locked   = 1'b1;
      u_if.sw_reset_req = 1'b0;

      // Bring-up table: entry n-1 holds the outputs expected just after edge n
      // following reset release (RELEASE entered at edge 14).
      for (int i = 0; i < 24; i++) begin
         n = i + 1;
         vecs[i].locked      = 1'b1;
         vecs[i].sw          = 1'b0;
         vecs[i].exp_pll_rst = (n < 4);
         vecs[i].exp_stage   = (n < 16) ? 3'b111 : (n < 18) ? 3'b110 : (n < 20) ? 3'b100 : 3'b000;
         vecs[i].exp_ready   = (n >= 21);
         vecs[i].exp_to      = 1'b0;
         vecs[i].exp_cnt     = 8'd0;
      end

      // Reset state
      tick();
      chk("rst_pll_rst", {31'd0, u_if.pll_rst}, 32'd1);
      chk("rst_stage", {29'd0, u_if.stage_rst}, 32'd7);
      chk("rst_ready", {31'd0, u_if.ready}, 32'd0);
      chk("rst_timeout", {31'd0, u_if.lock_timeout}, 32'd0);
      chk("rst_count", {24'd0, u_if.lock_loss_count}, 32'd0);
      tick();
      rst = 1'b0;

      // Nominal bring-up
      for (int i = 0; i < 24; i++) begin
         u_if.pll_locked   = vecs[i].locked;
         u_if.sw_reset_req = vecs[i].sw;
         tick();
         chk("nom_pll_rst", {31'd0, u_if.pll_rst}, {31'd0, vecs[i].exp_pll_rst});
         chk("nom_stage", {29'd0, u_if.stage_rst}, {29'd0, vecs[i].exp_stage});
         chk("nom_ready", {31'd0, u_if.ready}, {31'd0, vecs[i].exp_ready});
         chk("nom_timeout", {31'd0, u_if.lock_timeout}, {31'd0, vecs[i].exp_to});
         chk("nom_count", {24'd0, u_if.lock_loss_count}, {24'd0, vecs[i].exp_cnt});
      end

      // Lock glitch in WAIT_LOCK: stable count is 5 after edge 11, glitch pushes release to edge 24
      do_reset();
      for (int i = 0; i < 11; i++) tick();
      u_if.pll_locked = 1'b0;
      tick();
      u_if.pll_locked = 1'b1;
      e = 12;
      while (u_if.stage_rst === 3'b111 && e < 60) begin
         tick();
         e++;
      end
      chk("glitch_release_edge", e, 32'd24);
      chk("glitch_stage", {29'd0, u_if.stage_rst}, 32'd6);
      chk("glitch_count", {24'd0, u_if.lock_loss_count}, 32'd0);

      // Timeout: WAIT_LOCK from edge 4, abandoned at edge 68
      u_if.pll_locked = 1'b0;
      do_reset();
      for (int i = 0; i < 67; i++) tick();
      chk("to_pll_rst_pre", {31'd0, u_if.pll_rst}, 32'd0);
      chk("to_flag_pre", {31'd0, u_if.lock_timeout}, 32'd0);
      tick();
      chk("to_pll_rst", {31'd0, u_if.pll_rst}, 32'd1);
      chk("to_flag", {31'd0, u_if.lock_timeout}, 32'd1);
      for (int i = 0; i < 3; i++) tick();
      chk("to_pll_rst_hold", {31'd0, u_if.pll_rst}, 32'd1);
      tick();
      chk("to_pll_rst_end", {31'd0, u_if.pll_rst}, 32'd0);
      u_if.pll_locked = 1'b1;
      for (int i = 0; i < 16; i++) tick();
      chk("to_ready_pre", {31'd0, u_if.ready}, 32'd0);
      chk("to_flag_sticky", {31'd0, u_if.lock_timeout}, 32'd1);
      tick();
      chk("to_ready", {31'd0, u_if.ready}, 32'd1);
      chk("to_flag_clear", {31'd0, u_if.lock_timeout}, 32'd0);

      // First lock loss, then sw_reset_req in RELEASE at stage_rst=110
      lose_lock(8'd1);
      e = 0;
      while (u_if.stage_rst !== 3'b110 && e < 100) begin
         tick();
         e++;
      end
      chk("sw_reach_110", {29'd0, u_if.stage_rst}, 32'd6);
      u_if.sw_reset_req = 1'b1;
      tick();
      u_if.sw_reset_req = 1'b0;
      chk("sw_stage", {29'd0, u_if.stage_rst}, 32'd7);
      chk("sw_pll_rst", {31'd0, u_if.pll_rst}, 32'd1);
      chk("sw_count", {24'd0, u_if.lock_loss_count}, 32'd1);
      tick();
      // Second request while in PLL_RST restarts the 4-cycle pulse
      u_if.sw_reset_req = 1'b1;
      tick();
      u_if.sw_reset_req = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      chk("sw_restart_hold", {31'd0, u_if.pll_rst}, 32'd1);
      tick();
      chk("sw_restart_end", {31'd0, u_if.pll_rst}, 32'd0);
      wait_ready("sw_recover_ready");
      chk("sw_count_after", {24'd0, u_if.lock_loss_count}, 32'd1);

      // Repeated lock loss until the counter saturates
      for (int i = 2; i <= 300; i++) begin
         lose_lock((i > 255) ? 8'd255 : 8'(i));
         wait_ready("loss_recover_ready");
      end
      chk("loss_saturated", {24'd0, u_if.lock_loss_count}, 32'd255);

      // Async reset between edges
      tick();
      #2;
      rst = 1'b1;
      #1;
      chk("arst_ready", {31'd0, u_if.ready}, 32'd0);
      chk("arst_pll_rst", {31'd0, u_if.pll_rst}, 32'd1);
      chk("arst_stage", {29'd0, u_if.stage_rst}, 32'd7);
      chk("arst_count", {24'd0, u_if.lock_loss_count}, 32'd0);
      tick();
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
